mem_ctrl: RTL and testbench

Single-port byte-RAM arbiter and sequencer. It answers the instruction fetch unit's byte-stream requests and the load/store buffer's 1/2/4-byte transactions, driving the RAM/IO port with 1-cycle read latency. It sits between fetch/LSB and the top-level `mem_a`/`mem_dout`/`mem_wr`/`mem_din` pins.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, load/store-buffer and RAM pin bundle for mem_ctrl.
// slave is the controller's view, master is the surrounding environment.
interface mem_ctrl_if;
  logic        rdy_in;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [7:0]  if_byte;
  logic        lsb_busy;
  logic        lsb_req;
  logic        lsb_wr;
  logic [2:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        rollback;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  rdy_in, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           rollback, io_buffer_full, mem_din,
    output if_rdy, if_byte, lsb_busy, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           rollback, io_buffer_full, mem_din,
    input  if_rdy, if_byte, lsb_busy, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-RAM arbiter. Serves the fetch byte stream when
// idle, otherwise sequences 1/2/4-byte LSB loads and stores one byte per cycle
// against a RAM with 1-cycle read latency.
// Optional feature: define IO_STALL_EN to hold IO-window store bytes while
// io_buffer_full is high.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input logic       clk_in,
  input logic       rst_in,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t      state, state_nx;
  logic [2:0]  issue_cnt, issue_nx, recv_cnt, recv_nx, size_r;
  logic [31:0] addr_r, wdata_r, rbuf, rbuf_nx, rdata_r;
  logic        done_r, done_nx, latch, rdata_ld;
  logic [31:0] seq_addr, re_addr;
  logic [5:0]  sh;
  logic [7:0]  seq_byte;
  logic        io_gate, io_acc, io_seq;
  logic [31:0] mem_a_c;
  logic [7:0]  mem_dout_c;
  logic        mem_wr_c, if_rdy_c, busy_c;

`ifdef IO_STALL_EN
  assign io_gate = bus.io_buffer_full;
`else
  logic unused_io;
  assign unused_io = bus.io_buffer_full;
  assign io_gate   = 1'b0;
`endif

  assign seq_addr = addr_r + {29'd0, issue_cnt};
  assign re_addr  = addr_r + {29'd0, recv_cnt};
  assign sh       = {recv_cnt, 3'b000};
  assign io_acc   = io_gate && (bus.lsb_addr[17:16] == IO_BASE[17:16]);
  assign io_seq   = io_gate && (seq_addr[17:16] == IO_BASE[17:16]);

  // Store byte lane for the byte currently being issued
  always_comb begin
    case (issue_cnt[1:0])
      2'd0:    seq_byte = wdata_r[7:0];
      2'd1:    seq_byte = wdata_r[15:8];
      2'd2:    seq_byte = wdata_r[23:16];
      default: seq_byte = wdata_r[31:24];
    endcase
  end

  // Next-state, counter and RAM-port decode
  always_comb begin
    state_nx   = state;
    issue_nx   = issue_cnt;
    recv_nx    = recv_cnt;
    rbuf_nx    = rbuf;
    done_nx    = 1'b0;
    rdata_ld   = 1'b0;
    latch      = 1'b0;
    mem_a_c    = bus.if_addr;
    mem_dout_c = '0;
    mem_wr_c   = 1'b0;
    if_rdy_c   = 1'b0;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lsb_req && !done_r) begin
          busy_c     = 1'b1;
          mem_a_c    = bus.lsb_addr;
          mem_dout_c = bus.lsb_wdata[7:0];
          if (bus.rdy_in) begin
            latch = 1'b1;
            if (bus.lsb_wr) begin
              mem_wr_c = !io_acc;
              if (io_acc) begin
                state_nx = STORE;
                issue_nx = '0;
              end else if (bus.lsb_size == 3'd1) begin
                done_nx = 1'b1;
              end else begin
                state_nx = STORE;
                issue_nx = 3'd1;
              end
            end else if (!bus.rollback) begin
              state_nx = LOAD;
              issue_nx = 3'd1;
              recv_nx  = '0;
              rbuf_nx  = '0;
            end
          end
        end else begin
          if_rdy_c = bus.rdy_in;
        end
      end
      LOAD: begin
        busy_c = 1'b1;
        if (bus.rdy_in) begin
          mem_a_c = seq_addr;
          if (issue_cnt != size_r) issue_nx = issue_cnt + 3'd1;
          rbuf_nx = (rbuf & ~(32'h0000_00FF << sh)) | ({24'd0, bus.mem_din} << sh);
          recv_nx = recv_cnt + 3'd1;
          if (recv_cnt + 3'd1 == size_r) begin
            state_nx = IDLE;
            issue_nx = '0;
            recv_nx  = '0;
            done_nx  = 1'b1;
            rdata_ld = 1'b1;
          end
        end else begin
          // The byte due this cycle is lost; re-read it now so capture
          // resumes on the first enabled cycle without a gap.
          mem_a_c  = re_addr;
          issue_nx = recv_cnt + 3'd1;
        end
        if (bus.rollback) begin
          state_nx = IDLE;
          issue_nx = '0;
          recv_nx  = '0;
          done_nx  = 1'b0;
          rdata_ld = 1'b0;
        end
      end
      STORE: begin
        busy_c     = 1'b1;
        mem_a_c    = seq_addr;
        mem_dout_c = seq_byte;
        if (bus.rdy_in && !io_seq) begin
          mem_wr_c = 1'b1;
          issue_nx = issue_cnt + 3'd1;
          if (issue_cnt + 3'd1 == size_r) begin
            state_nx = IDLE;
            issue_nx = '0;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!bus.rdy_in) begin
      mem_wr_c = 1'b0;
      if_rdy_c = 1'b0;
    end
  end

  // State, counters, request latch and registered LSB results
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      addr_r    <= '0;
      size_r    <= '0;
      wdata_r   <= '0;
      rbuf      <= '0;
      rdata_r   <= '0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_nx;
      recv_cnt  <= recv_nx;
      rbuf      <= rbuf_nx;
      done_r    <= done_nx;
      if (rdata_ld) rdata_r <= rbuf_nx;
      if (latch) begin
        addr_r  <= bus.lsb_addr;
        size_r  <= bus.lsb_size;
        wdata_r <= bus.lsb_wdata;
      end
    end
  end

  assign bus.if_byte   = bus.mem_din;
  assign bus.lsb_done  = done_r;
  assign bus.lsb_rdata = rdata_r;
  assign bus.mem_a     = rst_in ? '0 : mem_a_c;
  assign bus.mem_dout  = rst_in ? '0 : mem_dout_c;
  assign bus.mem_wr    = rst_in ? 1'b0 : mem_wr_c;
  assign bus.if_rdy    = rst_in ? 1'b0 : if_rdy_c;
  assign bus.lsb_busy  = rst_in ? 1'b0 : busy_c;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: bench for mem_ctrl with a behavioural RAM and a byte-array
// reference memory; expected timing is derived from the transaction rules.
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_BASE(32'h30000)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus.slave)
  );

  logic [7:0] ram     [0:262143];
  bit         written [0:262143];
  logic [7:0] model   [0:262143];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;

  function automatic logic [7:0] init_byte(input logic [17:0] a);
    logic [17:0] t;
    case (a)
      18'h01000: return 8'h11;
      18'h01001: return 8'h22;
      18'h01002: return 8'h33;
      18'h01003: return 8'h44;
      default: begin
        t = (a * 18'd37) ^ (a >> 3);
        return t[7:0];
      end
    endcase
  endfunction

  // RAM with 1-cycle read latency
  always @(posedge clk_in) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a[17:0]]     <= bus.mem_dout;
      written[bus.mem_a[17:0]] <= 1'b1;
    end
    bus.mem_din <= written[bus.mem_a[17:0]] ? ram[bus.mem_a[17:0]] : init_byte(bus.mem_a[17:0]);
  end

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    bus.rdy_in = 1'b1; bus.if_addr = 32'h1234; bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1;
    bus.lsb_size = 3'd4; bus.lsb_addr = 32'h2000; bus.lsb_wdata = 32'hA5A5A5A5;
    bus.rollback = 1'b0; bus.io_buffer_full = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if ({bus.if_rdy, bus.lsb_busy, bus.lsb_done, bus.mem_wr} !== 4'b0 || bus.lsb_rdata !== '0 ||
          bus.mem_a !== '0 || bus.mem_dout !== '0) begin
        errors++;
        $display("FAIL reset: if_rdy=%b busy=%b done=%b wr=%b rdata=%h a=%h dout=%h want all 0",
                 bus.if_rdy, bus.lsb_busy, bus.lsb_done, bus.mem_wr, bus.lsb_rdata, bus.mem_a, bus.mem_dout);
      end
      step();
    end
    bus.lsb_req = 1'b0;
    rst_in = 1'b0;
  endtask

  task automatic test_fetch;
    logic [31:0] a, prev;
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      a = (i < 4) ? 32'(i) : 32'($urandom_range(0, 32'h3FFFF));
      bus.if_addr = a;
      @(negedge clk_in);
      checks++;
      if (bus.if_rdy !== 1'b1 || bus.mem_a !== a || bus.mem_wr !== 1'b0 || bus.lsb_busy !== 1'b0) begin
        errors++;
        $display("FAIL fetch_issue: if_rdy=%b a=%h wr=%b busy=%b want 1 %h 0 0",
                 bus.if_rdy, bus.mem_a, bus.mem_wr, bus.lsb_busy, a);
      end
      if (i > 0) begin
        checks++;
        if (bus.if_byte !== model[prev[17:0]]) begin
          errors++;
          $display("FAIL fetch_byte: addr %h got %h want %h", prev, bus.if_byte, model[prev[17:0]]);
        end
      end
      prev = a;
      step();
    end
  endtask

  task automatic run_load(input logic [31:0] a, input int n, input int lo_at, input int lo_len);
    logic [31:0] exp;
    int exp_done;
    exp = '0;
    for (int i = 0; i < n; i++) exp = exp | ({24'd0, model[a[17:0] + 18'(i)]} << (8 * i));
    exp_done = n + 1 + lo_len;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 3'(n); bus.lsb_addr = a;
    bus.lsb_wdata = $urandom();
    for (int cyc = 0; cyc <= exp_done; cyc++) begin
      bus.rdy_in = (lo_len > 0 && cyc >= lo_at && cyc < lo_at + lo_len) ? 1'b0 : 1'b1;
      bus.if_addr = 32'($urandom_range(0, 32'h3FFFF));
      @(negedge clk_in);
      if (cyc == exp_done) begin
        checks++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== exp) begin
          errors++;
          $display("FAIL load_done: addr %h n %0d done=%b rdata=%h want 1 %h", a, n, bus.lsb_done, bus.lsb_rdata, exp);
        end
        checks++;
        if (bus.if_rdy !== 1'b1 || bus.lsb_busy !== 1'b0) begin
          errors++;
          $display("FAIL load_done_no_accept: if_rdy=%b busy=%b want 1 0", bus.if_rdy, bus.lsb_busy);
        end
      end else begin
        checks++;
        if (bus.lsb_done !== 1'b0 || bus.lsb_busy !== 1'b1 || bus.if_rdy !== 1'b0 || bus.mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL load_busy: cyc %0d done=%b busy=%b if_rdy=%b wr=%b want 0 1 0 0",
                   cyc, bus.lsb_done, bus.lsb_busy, bus.if_rdy, bus.mem_wr);
        end
        if (lo_len == 0 && cyc < n) begin
          checks++;
          if (bus.mem_a !== a + 32'(cyc)) begin
            errors++;
            $display("FAIL load_addr: cyc %0d got %h want %h", cyc, bus.mem_a, a + 32'(cyc));
          end
        end
      end
      step();
    end
    bus.lsb_req = 1'b0; bus.rdy_in = 1'b1;
    last_rdata = exp;
  endtask

  task automatic run_store(input logic [31:0] a, input int n, input logic [31:0] d, input int lo_at,
                           input int lo_len, input int full_len, input int rb_at);
    int j;
    bit blk, seen;
    logic [31:0] ba;
    logic [7:0] b;
    j = 0; seen = 0;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 3'(n); bus.lsb_addr = a; bus.lsb_wdata = d;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      bus.rdy_in = (cyc >= lo_at && cyc < lo_at + lo_len) ? 1'b0 : 1'b1;
      bus.io_buffer_full = (cyc < full_len);
      bus.rollback = (cyc == rb_at);
      @(negedge clk_in);
      if (j == n) begin
        seen = 1;
        checks++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_busy !== 1'b0 || bus.if_rdy !== 1'b1 || bus.mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL store_done: cyc %0d done=%b busy=%b if_rdy=%b wr=%b want 1 0 1 0",
                   cyc, bus.lsb_done, bus.lsb_busy, bus.if_rdy, bus.mem_wr);
        end
      end else begin
        ba = a + 32'(j);
        blk = !bus.rdy_in;
`ifdef IO_STALL_EN
        if (bus.io_buffer_full && ba[17:16] == 2'b11) blk = 1;
`endif
        checks++;
        if (bus.lsb_busy !== 1'b1 || bus.if_rdy !== 1'b0 || bus.lsb_done !== 1'b0 || bus.mem_wr !== !blk) begin
          errors++;
          $display("FAIL store_cycle: cyc %0d busy=%b if_rdy=%b done=%b wr=%b want 1 0 0 %b",
                   cyc, bus.lsb_busy, bus.if_rdy, bus.lsb_done, bus.mem_wr, !blk);
        end
        if (!blk) begin
          b = d[8*j +: 8];
          checks++;
          if (bus.mem_a !== ba || bus.mem_dout !== b) begin
            errors++;
            $display("FAIL store_byte: byte %0d got %h@%h want %h@%h", j, bus.mem_dout, bus.mem_a, b, ba);
          end
          model[ba[17:0]] = b;
          j++;
        end
      end
      step();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL store_timeout: wrote %0d of %0d bytes, no lsb_done", j, n);
    end
    bus.lsb_req = 1'b0; bus.rdy_in = 1'b1; bus.io_buffer_full = 1'b0; bus.rollback = 1'b0;
  endtask

  task automatic test_load_basic;
    run_load(32'h1000, 4, -1, 0);
  endtask

  task automatic test_store_load;
    run_store(32'h2002, 2, 32'h0000BEEF, -1, 0, 0, -1);
    run_load(32'h2002, 2, -1, 0);
    checks++;
    if (last_rdata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL store_load_model: got %h want 0000beef", last_rdata);
    end
  endtask

  task automatic test_rollback;
    // load aborted in its third cycle
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 3'd4; bus.lsb_addr = 32'h5000;
    for (int cyc = 0; cyc < 3; cyc++) begin
      bus.rollback = (cyc == 2);
      @(negedge clk_in);
      checks++;
      if (bus.lsb_done !== 1'b0 || bus.lsb_busy !== 1'b1) begin
        errors++;
        $display("FAIL rb_load_busy: cyc %0d done=%b busy=%b want 0 1", cyc, bus.lsb_done, bus.lsb_busy);
      end
      step();
    end
    bus.lsb_req = 1'b0; bus.rollback = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk_in);
      checks++;
      if (bus.if_rdy !== 1'b1 || bus.lsb_busy !== 1'b0 || bus.lsb_done !== 1'b0 || bus.lsb_rdata !== last_rdata) begin
        errors++;
        $display("FAIL rb_load_idle: if_rdy=%b busy=%b done=%b rdata=%h want 1 0 0 %h",
                 bus.if_rdy, bus.lsb_busy, bus.lsb_done, bus.lsb_rdata, last_rdata);
      end
      step();
    end
    // rollback in the accept cycle of a load
    bus.lsb_req = 1'b1; bus.rollback = 1'b1;
    @(negedge clk_in);
    checks++;
    if (bus.lsb_busy !== 1'b1 || bus.if_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rb_accept: busy=%b if_rdy=%b want 1 0", bus.lsb_busy, bus.if_rdy);
    end
    step();
    bus.lsb_req = 1'b0; bus.rollback = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.if_rdy !== 1'b1 || bus.lsb_busy !== 1'b0 || bus.lsb_done !== 1'b0) begin
      errors++;
      $display("FAIL rb_accept_idle: if_rdy=%b busy=%b done=%b want 1 0 0", bus.if_rdy, bus.lsb_busy, bus.lsb_done);
    end
    step();
    // stores ignore rollback
    run_store(32'h6000, 2, 32'h00001234, -1, 0, 0, 1);
    run_load(32'h6000, 2, -1, 0);
  endtask

  task automatic test_rdy_stall;
    run_load(32'h1000, 4, 2, 2);
    run_load(32'h1000, 4, 1, 1);
    run_store(32'h7000, 4, $urandom(), 1, 2, 0, -1);
    run_load(32'h7000, 4, -1, 0);
  endtask

  task automatic test_io;
    run_store(32'h30000, 1, 32'h0000005A, -1, 0, 3, -1);
    run_store(32'h8000, 2, $urandom(), -1, 0, 3, -1);
    run_load(32'h8000, 2, -1, 0);
  endtask

  task automatic test_back_to_back;
    int sizes [3] = '{1, 2, 4};
    int n;
    logic [31:0] a, last_st;
    last_st = 32'h9000;
    for (int i = 0; i < 20; i++) begin
      n = sizes[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 0) begin
        a = 32'($urandom_range(32'h4000, 32'h2FFF0));
        last_st = a;
        run_store(a, n, $urandom(), -1, 0, 0, -1);
      end else begin
        a = ($urandom_range(0, 1) == 0) ? last_st : 32'($urandom_range(32'h4000, 32'h2FFF0));
        run_load(a, n, -1, 0);
      end
      if ($urandom_range(0, 2) == 0) step();
    end
  endtask

  task automatic test_reset_mid;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 3'd4; bus.lsb_addr = 32'h1000;
    step(); step();
    rst_in = 1'b1; bus.lsb_req = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.if_rdy !== 1'b0 || bus.lsb_busy !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_a !== '0 || bus.lsb_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: if_rdy=%b busy=%b wr=%b a=%h done=%b want all 0",
               bus.if_rdy, bus.lsb_busy, bus.mem_wr, bus.mem_a, bus.lsb_done);
    end
    step();
    rst_in = 1'b0;
    last_rdata = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_in);
      checks++;
      if (bus.if_rdy !== 1'b1 || bus.lsb_done !== 1'b0 || bus.lsb_rdata !== '0) begin
        errors++;
        $display("FAIL reset_mid_after: if_rdy=%b done=%b rdata=%h want 1 0 0", bus.if_rdy, bus.lsb_done, bus.lsb_rdata);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) model[i] = init_byte(18'(i));
    test_reset();
    test_fetch();
    test_load_basic();
    test_store_load();
    test_rollback();
    test_rdy_stall();
    test_io();
    test_back_to_back();
    test_reset_mid();
    test_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
